ula_arbiter: RTL and testbench

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter.sv | 154 +++++++++++++++
 tb/tb_ula_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin front end for two requesters that share one ALU and one comparator.
// Optional macro ULA_ARBITER_STATS_EN adds saturating per-requester grant counters.
module ula #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         carry,
    output logic         overflow,
    output logic         negative
);
    logic [W:0] sum;
    always_comb begin
        sum      = op[0] ? {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1} : {1'b0, a} + {1'b0, b};
        result   = op[1] ? (op[0] ? a | b : a & b) : sum[W-1:0];
        carry    = ~op[1] & sum[W];
        // signed overflow: operands effectively share a sign but the result does not
        overflow = ~op[1] & (a[W-1] ^ sum[W-1]) & ~(a[W-1] ^ b[W-1] ^ op[0]);
        zero     = result == '0;
        negative = result[W-1];
    end
endmodule

module ula_cmp (
    input  logic carry,
    input  logic zero,
    output logic hs,
    output logic ls,
    output logic hi,
    output logic lo
);
    assign hs = carry;
    assign lo = ~carry;
    assign hi = carry & ~zero;
    assign ls = ~carry | zero;
endmodule

module ula_arbiter #(
    parameter int ULA_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [ULA_BITS-1:0] req0_a,
    input  logic [ULA_BITS-1:0] req0_b,
    input  logic [ULA_BITS-1:0] req1_a,
    input  logic [ULA_BITS-1:0] req1_b,
    input  logic [1:0]          req0_op,
    input  logic [1:0]          req1_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [ULA_BITS-1:0] rsp_result,
    output logic                rsp_zero,
    output logic                rsp_carry,
    output logic                rsp_overflow,
    output logic                rsp_negative,
    output logic                rsp_hs,
    output logic                rsp_ls,
    output logic                rsp_hi,
    output logic                rsp_lo,
    output logic [15:0]         grant_cnt0,
    output logic [15:0]         grant_cnt1
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state;
    logic                ptr;
    logic [ULA_BITS-1:0] op_a, op_b, alu_result;
    logic [1:0]          op_op;
    logic                op_id;
    logic                alu_zero, alu_carry, alu_overflow, alu_negative;
    logic                cmp_hs, cmp_ls, cmp_hi, cmp_lo;

    // ptr names the requester that wins when both are valid
    assign req0_ready = state == IDLE && req0_valid && (!req1_valid || !ptr);
    assign req1_ready = state == IDLE && req1_valid && (!req0_valid || ptr);
    assign rsp_valid  = state == RESP;

    ula #(.W(ULA_BITS)) u_ula (
        .a(op_a), .b(op_b), .op(op_op), .result(alu_result),
        .zero(alu_zero), .carry(alu_carry), .overflow(alu_overflow), .negative(alu_negative)
    );

    ula_cmp u_cmp (
        .carry(alu_carry), .zero(alu_zero),
        .hs(cmp_hs), .ls(cmp_ls), .hi(cmp_hi), .lo(cmp_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_op        <= '0;
            op_id        <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_hs       <= 1'b0;
            rsp_ls       <= 1'b0;
            rsp_hi       <= 1'b0;
            rsp_lo       <= 1'b0;
        end else if (req0_ready || req1_ready) begin
            op_a  <= req1_ready ? req1_a : req0_a;
            op_b  <= req1_ready ? req1_b : req0_b;
            op_op <= req1_ready ? req1_op : req0_op;
            op_id <= req1_ready;
            ptr   <= ~req1_ready;
            state <= EXEC;
        end else if (state == EXEC) begin
            rsp_id       <= op_id;
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_negative <= alu_negative;
            rsp_hs       <= cmp_hs;
            rsp_ls       <= cmp_ls;
            rsp_hi       <= cmp_hi;
            rsp_lo       <= cmp_lo;
            state        <= RESP;
        end else if (state == RESP && rsp_ready) begin
            state <= IDLE;
        end
    end

`ifdef ULA_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && ~&grant_cnt0) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_ready && ~&grant_cnt1) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed and random operations against a plain-arithmetic reference model.
module tb_ula_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [3:0]  rsp_result;
    logic        rsp_zero, rsp_carry, rsp_overflow, rsp_negative;
    logic        rsp_hs, rsp_ls, rsp_hi, rsp_lo;
    logic [15:0] grant_cnt0, grant_cnt1;

`ifdef ULA_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int nvec = 0, nerr = 0;
    int mptr = 0, mcnt0 = 0, mcnt1 = 0;

    ula_arbiter #(.ULA_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow), .rsp_negative(rsp_negative),
        .rsp_hs(rsp_hs), .rsp_ls(rsp_ls), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {id, result, z, c, v, n, hs, ls, hi, lo} from integer arithmetic
    function automatic logic [12:0] model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        int ua, ub, sa, sb, r, sr;
        logic c, v, z, n;
        ua = int'(a);
        ub = int'(b);
        sa = ua >= 8 ? ua - 16 : ua;
        sb = ub >= 8 ? ub - 16 : ub;
        sr = op == 2'd0 ? sa + sb : sa - sb;
        r  = op == 2'd0 ? ua + ub : op == 2'd1 ? ua - ub + 16 : op == 2'd2 ? int'(a & b) : int'(a | b);
        c  = op == 2'd0 ? ua + ub >= 16 : op == 2'd1 ? ua >= ub : 1'b0;
        v  = op[1] ? 1'b0 : (sr > 7 || sr < -8);
        r  = r % 16;
        z  = r == 0;
        n  = r >= 8;
        return {id, 4'(r), z, c, v, n, c, !c || z, c && !z, !c};
    endfunction

    function automatic logic [12:0] obs_rsp();
        return {rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_negative,
                rsp_hs, rsp_ls, rsp_hi, rsp_lo};
    endfunction

    task automatic chk_cnt();
        chk("grant_cnt0", 32'(grant_cnt0), STATS ? 32'(mcnt0) : 32'd0);
        chk("grant_cnt1", 32'(grant_cnt1), STATS ? 32'(mcnt1) : 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp", 32'(obs_rsp()), 32'd0);
        mptr = 0; mcnt0 = 0; mcnt1 = 0;
        chk_cnt();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic run_op(input logic v0, input logic v1,
                          input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] op0,
                          input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] op1,
                          input int hold);
        logic g1;
        logic [12:0] exp;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready = 1'b0;
        #1;
        g1 = v1 && (!v0 || mptr == 1);
        chk("req0_ready", 32'(req0_ready), 32'(v0 && !g1));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        if (!(v0 || v1)) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_valid", 32'(rsp_valid), 32'd0);
            return;
        end
        exp = g1 ? model(1'b1, a1, b1, op1) : model(1'b0, a0, b0, op0);
        mptr = g1 ? 0 : 1;
        if (g1) mcnt1 = mcnt1 < 65535 ? mcnt1 + 1 : mcnt1;
        else    mcnt0 = mcnt0 < 65535 ? mcnt0 + 1 : mcnt0;
        @(posedge clk);
        #1;
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
        @(negedge clk);
        chk("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("exec_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(obs_rsp()), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(obs_rsp()), 32'(exp));
            chk("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk_cnt();
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // both valid continuously: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++)
            run_op(1'b1, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom),
                   4'($urandom), 4'($urandom), 2'($urandom), 0);
        chk("alt_cnt0", 32'(grant_cnt0), STATS ? 32'd2 : 32'd0);
        chk("alt_cnt1", 32'(grant_cnt1), STATS ? 32'd2 : 32'd0);
        run_op(1'b1, 1'b0, 4'b0101, 4'b0011, 2'b00, 4'd0, 4'd0, 2'b00, 0);
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 4'b0011, 4'b0011, 2'b01, 0);
        run_op(1'b1, 1'b0, 4'b1100, 4'b1010, 2'b10, 4'd0, 4'd0, 2'b00, 0);
        run_op(1'b1, 1'b0, 4'b1100, 4'b1010, 2'b11, 4'd0, 4'd0, 2'b00, 0);
        run_op(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 2'b00, 0);
        run_op(1'b1, 1'b1, 4'b0111, 4'b0001, 2'b00, 4'b1000, 4'b0001, 2'b01, 5);
        // reset while EXEC holds an accepted req0 op (pointer had moved to 1)
        req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b0001; req0_op = 2'b00;
        req1_valid = 1'b0;
        #1;
        chk("pre_rst_ready0", 32'(req0_ready), 32'(mptr == 0));
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("discarded_valid", 32'(rsp_valid), 32'd0);
        end
        run_op(1'b1, 1'b1, 4'b0010, 4'b0001, 2'b01, 4'b1111, 4'b0001, 2'b00, 1);
        for (int i = 0; i < 24; i++)
            run_op(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
                   4'($urandom), 4'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
